// File: rtl/clock_cfg_sequencer_pkg.sv
// Shared cfg-word bit positions, FSM encodings and source-requirement helpers
// for the cog-clock cfg sequencer.
package clock_cfg_pkg;

  localparam int CFG_RESET      = 7;
  localparam int CFG_PLLENA     = 6;
  localparam int CFG_OSCENA     = 5;
  localparam int CFG_OSCM1      = 4;
  localparam int CFG_OSCM0      = 3;
  localparam int CFG_CLKSEL_MSB = 2;
  localparam int CFG_CLKSEL_LSB = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_RST_PULSE  = 2'd1;
  localparam state_t ST_WAIT_START = 2'd2;
  localparam state_t ST_SETTLE     = 2'd3;

  // CLKSEL 010 runs straight off the crystal oscillator; 011 and up go through the PLL.
  function automatic logic needs_osc(input logic [2:0] clksel);
    return clksel >= 3'b010;
  endfunction

  function automatic logic needs_pll(input logic [2:0] clksel);
    return clksel >= 3'b011;
  endfunction

endpackage

// File: rtl/clock_cfg_sequencer_if.sv
// CLKSET request handshake plus the cfg/status outputs of the sequencer.
interface clock_cfg_sequencer_if;
  logic       req_valid;
  logic [7:0] req_cfg;
  logic       req_ready;
  logic [6:0] cfg;
  logic       busy;
  logic       sw_reset;
  logic       cfg_err;

  modport master (
    output req_valid, req_cfg,
    input  req_ready, cfg, busy, sw_reset, cfg_err
  );

  modport slave (
    input  req_valid, req_cfg,
    output req_ready, cfg, busy, sw_reset, cfg_err
  );
endinterface

// File: rtl/clock_cfg_sequencer_delay_counter.sv
// Loadable down-counter; holds at zero, load takes priority over counting.
module cfg_delay_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (res) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clock_cfg_sequencer.sv
// Sequences CLKSET requests onto the 7-bit cog-clock cfg word: enable, wait startup,
// switch, settle, then drop unused enables. Runs on the free-running input clock.
module clock_cfg_sequencer
  import clock_cfg_pkg::*;
#(
  parameter int STARTUP_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES  = 16384,
  parameter int RESET_CYCLES   = 16,
  parameter int CNT_W = $clog2(((STARTUP_CYCLES > SETTLE_CYCLES)
                                ? ((STARTUP_CYCLES > RESET_CYCLES) ? STARTUP_CYCLES : RESET_CYCLES)
                                : ((SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES)) + 1)
) (
  input  logic                  clk_in,
  input  logic                  res,
  clock_cfg_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LD_START  = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_RESET  = CNT_W'(RESET_CYCLES - 1);

  state_t           state;
  logic [6:0]       cfg_q;
  logic [6:0]       nxt_q;
  logic             sw_reset_q;
  logic             cfg_err_q;
  logic             ready;
  logic             accept;
  logic [6:0]       req7;
  logic [1:0]       rise;
  logic [1:0]       ena_or;
  logic [2:0]       req_sel;
  logic             req_bad;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  assign ready   = (state == ST_IDLE) && !res;
  assign accept  = bus.req_valid && ready;
  assign req7    = bus.req_cfg[6:0];
  assign rise    = req7[CFG_PLLENA:CFG_OSCENA] & ~cfg_q[CFG_PLLENA:CFG_OSCENA];
  assign ena_or  = req7[CFG_PLLENA:CFG_OSCENA] | cfg_q[CFG_PLLENA:CFG_OSCENA];
  assign req_sel = req7[CFG_CLKSEL_MSB:CFG_CLKSEL_LSB];
  assign req_bad = (needs_pll(req_sel) && !(req7[CFG_PLLENA] && req7[CFG_OSCENA]))
                || (needs_osc(req_sel) && !req7[CFG_OSCENA]);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_cfg[CFG_RESET]) begin
            cnt_load = 1'b1;
            cnt_val  = LD_RESET;
          end else if (req7 != cfg_q) begin
            cnt_load = 1'b1;
            cnt_val  = (rise != 2'b00) ? LD_START : LD_SETTLE;
          end
        end
      end
      ST_WAIT_START: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LD_SETTLE;
        end
      end
      default: ;
    endcase
  end

  cfg_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk   (clk_in),
    .res   (res),
    .load  (cnt_load),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk_in) begin
    if (res) begin
      state      <= ST_IDLE;
      cfg_q      <= 7'h00;
      nxt_q      <= 7'h00;
      sw_reset_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            nxt_q <= req7;
            if (bus.req_cfg[CFG_RESET]) begin
              cfg_q      <= 7'h00;
              sw_reset_q <= 1'b1;
              state      <= ST_RST_PULSE;
            end else begin
              cfg_err_q <= req_bad;
              if (req7 != cfg_q) begin
                // New enables come up first; mode bits go early, the mux only moves once the source is stable.
                if (rise != 2'b00) begin
                  cfg_q <= {ena_or, req7[CFG_OSCM1:CFG_OSCM0], cfg_q[CFG_CLKSEL_MSB:CFG_CLKSEL_LSB]};
                  state <= ST_WAIT_START;
                end else begin
                  cfg_q <= {ena_or, req7[CFG_OSCM1:CFG_CLKSEL_LSB]};
                  state <= ST_SETTLE;
                end
              end
            end
          end
        end
        ST_RST_PULSE: begin
          if (cnt_zero) begin
            sw_reset_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_WAIT_START: begin
          if (cnt_zero) begin
            cfg_q <= {cfg_q[CFG_PLLENA:CFG_OSCENA], nxt_q[CFG_OSCM1:CFG_CLKSEL_LSB]};
            state <= ST_SETTLE;
          end
        end
        default: begin
          // Enables no longer wanted are only dropped after the BUFGMUX has moved off them.
          if (cnt_zero) begin
            cfg_q <= nxt_q;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cfg       = cfg_q;
  assign bus.sw_reset  = sw_reset_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clock_cfg_sequencer.sv
// Directed bench for clock_cfg_sequencer with shortened startup/settle/reset timings.
module tb_clock_cfg_sequencer;

  logic clk_in = 1'b0;
  logic res;
  int   total = 0;
  int   bad   = 0;
  logic err_seen;

  clock_cfg_sequencer_if bus ();

  clock_cfg_sequencer #(
    .STARTUP_CYCLES (8),
    .SETTLE_CYCLES  (4),
    .RESET_CYCLES   (3)
  ) dut (
    .clk_in (clk_in),
    .res    (res),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (bus.cfg_err) err_seen = 1'b1;
  endtask

  task automatic send(input logic [7:0] v);
    bus.req_cfg   = v;
    bus.req_valid = 1'b1;
    err_seen      = 1'b0;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    res           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cfg   = 8'h00;
    repeat (3) tick();
    check("ready_in_reset", 32'(bus.req_ready), 32'd0);
    res = 1'b0;
    #1;
    check("rst_cfg",      32'(bus.cfg),       32'h00);
    check("rst_ready",    32'(bus.req_ready), 32'd1);
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_sw_reset", 32'(bus.sw_reset),  32'd0);

    // enable osc+PLL from RCFAST
    send(8'h6F);
    check("up_t1_cfg",    32'(bus.cfg),       32'h68);
    check("up_t1_busy",   32'(bus.busy),      32'd1);
    check("up_t1_ready",  32'(bus.req_ready), 32'd0);
    repeat (7) tick();
    check("up_wait_end_cfg", 32'(bus.cfg), 32'h68);
    tick();
    check("up_switch_cfg", 32'(bus.cfg), 32'h6F);
    repeat (3) tick();
    check("up_settle_busy", 32'(bus.busy), 32'd1);
    tick();
    check("up_ready_t13", 32'(bus.req_ready), 32'd1);
    check("up_final_cfg", 32'(bus.cfg),       32'h6F);
    check("up_no_err",    32'(err_seen),      32'd0);

    // back to RCFAST: switch first, drop enables after settle
    send(8'h00);
    check("down_t1_cfg", 32'(bus.cfg), 32'h60);
    repeat (3) tick();
    check("down_settle_cfg",  32'(bus.cfg),  32'h60);
    check("down_settle_busy", 32'(bus.busy), 32'd1);
    tick();
    check("down_final_cfg", 32'(bus.cfg),       32'h00);
    check("down_ready_t5",  32'(bus.req_ready), 32'd1);

    // PLL select without enables
    send(8'h07);
    check("err_pulse", 32'(bus.cfg_err), 32'd1);
    check("err_t1_cfg", 32'(bus.cfg),    32'h07);
    tick();
    check("err_pulse_end", 32'(bus.cfg_err), 32'd0);
    repeat (2) tick();
    check("err_busy", 32'(bus.busy), 32'd1);
    tick();
    check("err_ready_t5", 32'(bus.req_ready), 32'd1);
    check("err_final_cfg", 32'(bus.cfg),      32'h07);

    // software reset pulse
    send(8'h80);
    check("swr_cfg",  32'(bus.cfg),      32'h00);
    check("swr_c1",   32'(bus.sw_reset), 32'd1);
    tick();
    check("swr_c2",   32'(bus.sw_reset), 32'd1);
    tick();
    check("swr_c3",   32'(bus.sw_reset), 32'd1);
    tick();
    check("swr_off",   32'(bus.sw_reset),  32'd0);
    check("swr_ready", 32'(bus.req_ready), 32'd1);

    // same value: no-op
    send(8'h00);
    check("noop_busy",  32'(bus.busy),      32'd0);
    check("noop_ready", 32'(bus.req_ready), 32'd1);
    check("noop_cfg",   32'(bus.cfg),       32'h00);

    // reset aborts WAIT_START; a request held meanwhile goes in afterwards
    send(8'h6F);
    check("abort_t1_cfg", 32'(bus.cfg), 32'h68);
    bus.req_cfg   = 8'h07;
    bus.req_valid = 1'b1;
    repeat (3) tick();
    check("held_ignored_cfg", 32'(bus.cfg),  32'h68);
    check("held_busy",        32'(bus.busy), 32'd1);
    res = 1'b1;
    #1;
    check("res_blocks_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("abort_cfg",  32'(bus.cfg),      32'h00);
    check("abort_busy", 32'(bus.busy),     32'd0);
    check("abort_swr",  32'(bus.sw_reset), 32'd0);
    res = 1'b0;
    #1;
    check("after_res_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("late_accept_err", 32'(bus.cfg_err), 32'd1);
    check("late_accept_cfg", 32'(bus.cfg),     32'h07);
    repeat (3) tick();
    check("late_busy", 32'(bus.busy), 32'd1);
    tick();
    check("late_ready", 32'(bus.req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
